// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and
// instruction-word field positions.
package seq_pkg;

    localparam int OP_WIDTH = 2;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = 2'b00;
    localparam logic [OP_WIDTH-1:0] OP_SUB  = 2'b01;
    localparam logic [OP_WIDTH-1:0] OP_MUL  = 2'b10;
    localparam logic [OP_WIDTH-1:0] OP_HALT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_LOAD,
        ST_EXEC,
        ST_STORE,
        ST_HALT
    } seq_state_t;

    // Instruction word is {opcode, src1, src2, dst}, MSB first.
    function automatic int instr_width(input int addr_width);
        return 3 * addr_width + OP_WIDTH;
    endfunction

    function automatic int src1_lsb(input int addr_width);
        return 2 * addr_width;
    endfunction

    function automatic int src2_lsb(input int addr_width);
        return addr_width;
    endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: ADD / SUB / MUL modulo 2^DATA_WIDTH.
// With SEQ_OVERFLOW_FLAG_EN defined it also reports carry-out, borrow, or a
// nonzero upper product half on o_overflow.
module seq_alu
    import seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [OP_WIDTH-1:0]   i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
`ifdef SEQ_OVERFLOW_FLAG_EN
    output logic                  o_overflow,
`endif
    output logic [DATA_WIDTH-1:0] o_result
);

`ifdef SEQ_OVERFLOW_FLAG_EN
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_diff;
    logic [2*DATA_WIDTH-1:0] w_prod;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_prod = (2*DATA_WIDTH)'(i_a) * (2*DATA_WIDTH)'(i_b);

    // Select result and the matching out-of-range indication
    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result   = w_sum[DATA_WIDTH-1:0];
                o_overflow = w_sum[DATA_WIDTH];
            end
            OP_SUB: begin
                o_result   = w_diff[DATA_WIDTH-1:0];
                o_overflow = w_diff[DATA_WIDTH];
            end
            OP_MUL: begin
                o_result   = w_prod[DATA_WIDTH-1:0];
                o_overflow = |w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            default: begin
                o_result   = '0;
                o_overflow = 1'b0;
            end
        endcase
    end
`else
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_diff;
    logic [DATA_WIDTH-1:0] w_prod;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_prod = i_a * i_b;

    // Select the truncated result for the opcode
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = w_sum;
            OP_SUB:  o_result = w_diff;
            OP_MUL:  o_result = w_prod;
            default: o_result = '0;
        endcase
    end
`endif

endmodule

// File: rtl/instruction_sequencer.sv
// Control FSM for the 2-bit-opcode memory-to-memory processor: fetch from a
// synchronous ROM, decode, hand operands off to the load handler, execute in
// seq_alu and write the result back. Optional macro SEQ_OVERFLOW_FLAG_EN adds
// a sticky overflow output.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter  int DATA_WIDTH              = 8,
    parameter  int DATA_MEMORY_SIZE        = 64,
    parameter  int INSTRUCTION_MEMORY_SIZE = 32,
    localparam int ADDR_WIDTH              = $clog2(DATA_MEMORY_SIZE),
    localparam int PC_WIDTH                = $clog2(INSTRUCTION_MEMORY_SIZE),
    localparam int INSTRUCTION_WIDTH       = instr_width(ADDR_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    output logic [PC_WIDTH-1:0]          imem_addr,
    output logic                         lh_enable,
    output logic [OP_WIDTH-1:0]          lh_opcode,
    output logic [ADDR_WIDTH-1:0]        lh_src1_addr,
    output logic [ADDR_WIDTH-1:0]        lh_src2_addr,
    output logic [ADDR_WIDTH-1:0]        lh_dst_addr,
    input  logic                         lh_ready,
    input  logic [OP_WIDTH-1:0]          lh_opcode_out,
    input  logic [DATA_WIDTH-1:0]        lh_src1,
    input  logic [DATA_WIDTH-1:0]        lh_src2,
    input  logic [ADDR_WIDTH-1:0]        lh_dst_out,
    input  logic [ADDR_WIDTH-1:0]        lh_addr_out,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_we,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
`ifdef SEQ_OVERFLOW_FLAG_EN
    output logic                         overflow,
`endif
    output logic                         busy,
    output logic                         done
);

    localparam int SRC1_LSB = src1_lsb(ADDR_WIDTH);
    localparam int SRC2_LSB = src2_lsb(ADDR_WIDTH);
    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(INSTRUCTION_MEMORY_SIZE - 1);

    seq_state_t                   r_state;
    logic [PC_WIDTH-1:0]          r_pc;
    logic [INSTRUCTION_WIDTH-1:0] r_ir;
    logic [DATA_WIDTH-1:0]        r_result;
    logic [DATA_WIDTH-1:0]        r_src1;
    logic [DATA_WIDTH-1:0]        r_src2;
    logic [OP_WIDTH-1:0]          r_op;
    logic [ADDR_WIDTH-1:0]        r_dst;
    logic [DATA_WIDTH-1:0]        w_alu_result;
`ifdef SEQ_OVERFLOW_FLAG_EN
    logic                         r_overflow;
    logic                         w_alu_overflow;
`endif

    seq_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_op       (r_op),
        .i_a        (r_src1),
        .i_b        (r_src2),
`ifdef SEQ_OVERFLOW_FLAG_EN
        .o_overflow (w_alu_overflow),
`endif
        .o_result   (w_alu_result)
    );

    // Sequencer FSM: state, PC, IR, latched operands and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_result   <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_op       <= '0;
            r_dst      <= '0;
`ifdef SEQ_OVERFLOW_FLAG_EN
            r_overflow <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    // Start (re)launches the program from the first word
                    if (start) begin
                        r_pc    <= '0;
                        r_state <= ST_FETCH;
`ifdef SEQ_OVERFLOW_FLAG_EN
                        r_overflow <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_ir    <= instr_in;
                    r_state <= (instr_in[INSTRUCTION_WIDTH-1 -: OP_WIDTH] == OP_HALT)
                               ? ST_HALT : ST_LOAD;
                end
                ST_LOAD: begin
                    if (lh_ready) begin
                        r_op    <= lh_opcode_out;
                        r_src1  <= lh_src1;
                        r_src2  <= lh_src2;
                        r_dst   <= lh_dst_out;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= w_alu_result;
`ifdef SEQ_OVERFLOW_FLAG_EN
                    if (w_alu_overflow) begin
                        r_overflow <= 1'b1;
                    end
`endif
                    r_state  <= ST_STORE;
                end
                ST_STORE: begin
                    // The last ROM word ends the program; the PC never wraps
                    if (r_pc == LAST_PC) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_pc    <= r_pc + 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_addr    = r_pc;
    assign lh_enable    = (r_state == ST_LOAD);
    assign lh_opcode    = r_ir[INSTRUCTION_WIDTH-1 -: OP_WIDTH];
    assign lh_src1_addr = r_ir[SRC1_LSB +: ADDR_WIDTH];
    assign lh_src2_addr = r_ir[SRC2_LSB +: ADDR_WIDTH];
    assign lh_dst_addr  = r_ir[ADDR_WIDTH-1:0];
    assign mem_we       = (r_state == ST_STORE);
    assign mem_wdata    = (r_state == ST_STORE) ? r_result : '0;
    assign busy         = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                          (r_state == ST_LOAD)  || (r_state == ST_EXEC)   ||
                          (r_state == ST_STORE);
    assign done         = (r_state == ST_HALT);
`ifdef SEQ_OVERFLOW_FLAG_EN
    assign overflow     = r_overflow;
`endif

    // Data-memory port arbitration: load handler reads in LOAD, write-back in STORE
    always_comb begin
        mem_addr = '0;
        if (r_state == ST_LOAD) begin
            mem_addr = lh_addr_out;
        end else if (r_state == ST_STORE) begin
            mem_addr = r_dst;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: ROM, data memory and a
// four-cycle load handler model around the DUT, table-driven ALU vectors plus
// HALT, full-ROM, busy-start and reset-abort sequences.
module tb_instruction_sequencer;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] MUL  = 2'b10;
    localparam logic [1:0] HLT  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [19:0] instr_in;
    logic [4:0]  imem_addr;
    logic        lh_enable;
    logic [1:0]  lh_opcode;
    logic [5:0]  lh_src1_addr, lh_src2_addr, lh_dst_addr;
    logic        lh_ready;
    logic [1:0]  lh_opcode_out;
    logic [7:0]  lh_src1, lh_src2;
    logic [5:0]  lh_dst_out, lh_addr_out;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        busy, done;
`ifdef SEQ_OVERFLOW_FLAG_EN
    logic        overflow;
`endif

    always #5 clk = ~clk;

    instruction_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .instr_in      (instr_in),
        .imem_addr     (imem_addr),
        .lh_enable     (lh_enable),
        .lh_opcode     (lh_opcode),
        .lh_src1_addr  (lh_src1_addr),
        .lh_src2_addr  (lh_src2_addr),
        .lh_dst_addr   (lh_dst_addr),
        .lh_ready      (lh_ready),
        .lh_opcode_out (lh_opcode_out),
        .lh_src1       (lh_src1),
        .lh_src2       (lh_src2),
        .lh_dst_out    (lh_dst_out),
        .lh_addr_out   (lh_addr_out),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
`ifdef SEQ_OVERFLOW_FLAG_EN
        .overflow      (overflow),
`endif
        .busy          (busy),
        .done          (done)
    );

    // ---------------- environment models ----------------
    logic [19:0] rom [32];
    logic [7:0]  dmem [64];
    logic [19:0] instr_q;
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [7:0]  pre_data = '0;
    int          wr_count = 0;
    int          lh_cycles = 0;
    int          viol_we = 0;
    int          viol_addr = 0;
    int          lh_cnt = 0;
    logic [7:0]  lh_s1_q = '0;

    // Synchronous ROM: data one cycle after the address
    always @(posedge clk) instr_q <= rom[imem_addr];
    assign instr_in = instr_q;

    // Data memory: combinational read, bench preload port, DUT write port
    always @(posedge clk) begin
        if (pre_we) begin
            dmem[pre_addr] <= pre_data;
        end else if (mem_we) begin
            dmem[mem_addr] <= mem_wdata;
            wr_count       <= wr_count + 1;
        end
    end

    // Load handler: two cycles per operand read, ready in the fourth cycle
    always @(posedge clk) begin
        if (!lh_enable) begin
            lh_cnt <= 0;
        end else begin
            lh_cnt <= lh_cnt + 1;
            if (lh_cnt == 1) lh_s1_q <= dmem[mem_addr];
        end
    end
    assign lh_addr_out   = (lh_cnt < 2) ? lh_src1_addr : lh_src2_addr;
    assign lh_ready      = lh_enable && (lh_cnt == 3);
    assign lh_src1       = lh_s1_q;
    assign lh_src2       = dmem[mem_addr];
    assign lh_opcode_out = lh_opcode;
    assign lh_dst_out    = lh_dst_addr;

    // Continuous protocol monitor
    always @(negedge clk) begin
        if (lh_enable) lh_cycles <= lh_cycles + 1;
        if (mem_we && !busy) viol_we <= viol_we + 1;
        if (!lh_enable && !mem_we && mem_addr != 6'd0) viol_addr <= viol_addr + 1;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [19:0] mk(input logic [1:0] op, input logic [5:0] s1,
                                       input logic [5:0] s2, input logic [5:0] d);
        return {op, s1, s2, d};
    endfunction

    task automatic poke(input logic [5:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we   = 1'b0;
    endtask

    logic       cap_valid;
    logic [1:0] cap_op;
    logic [5:0] cap_s1, cap_s2, cap_dst;

    // Pulse start, then count cycles until done (bounded); capture first LOAD fields
    task automatic run_prog(input int limit, output int cycles);
        cap_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
            if (lh_enable && !cap_valid) begin
                cap_valid = 1'b1;
                cap_op    = lh_opcode;
                cap_s1    = lh_src1_addr;
                cap_s2    = lh_src2_addr;
                cap_dst   = lh_dst_addr;
            end
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] dst;
        logic [7:0] exp;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int cyc;
        int w0;
        int l0;
        int good;

        vecs[0] = '{ADD, 8'd5,   8'd7,   6'd3, 8'h0C, 1'b0};
        vecs[1] = '{SUB, 8'd3,   8'd5,   6'd4, 8'hFE, 1'b1};
        vecs[2] = '{MUL, 8'd20,  8'd13,  6'd5, 8'h04, 1'b1};
        vecs[3] = '{ADD, 8'd200, 8'd100, 6'd6, 8'h2C, 1'b1};
        vecs[4] = '{SUB, 8'd9,   8'd4,   6'd7, 8'h05, 1'b0};
        vecs[5] = '{MUL, 8'd15,  8'd17,  6'd8, 8'hFF, 1'b0};
        vecs[6] = '{ADD, 8'd255, 8'd1,   6'd9, 8'h00, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = mk(HLT, 6'd0, 6'd0, 6'd0);
        for (int i = 0; i < 64; i++) poke(6'(i), 8'h00);

        // Reset state
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_lh_bus", 32'({lh_enable, lh_opcode, lh_src1_addr, lh_src2_addr, lh_dst_addr}), 32'd0);
        check("rst_mem_port", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
`ifdef SEQ_OVERFLOW_FLAG_EN
        check("rst_overflow", 32'(overflow), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single-instruction programs
        for (int v = 0; v < 7; v++) begin
            poke(6'd1, vecs[v].a);
            poke(6'd2, vecs[v].b);
            poke(vecs[v].dst, 8'hAA);
            rom[0] = mk(vecs[v].op, 6'd1, 6'd2, vecs[v].dst);
            rom[1] = mk(HLT, 6'd0, 6'd0, 6'd0);
            w0 = wr_count;
            run_prog(40, cyc);
            check($sformatf("v%0d_done", v), 32'(done), 32'd1);
            check($sformatf("v%0d_latency", v), 32'(cyc), 32'd10);
            check($sformatf("v%0d_result", v), 32'(dmem[vecs[v].dst]), 32'(vecs[v].exp));
            check($sformatf("v%0d_writes", v), 32'(wr_count - w0), 32'd1);
            check($sformatf("v%0d_lh_fields", v), 32'({cap_valid, cap_op, cap_s1, cap_s2, cap_dst}),
                  32'({1'b1, vecs[v].op, 6'd1, 6'd2, vecs[v].dst}));
`ifdef SEQ_OVERFLOW_FLAG_EN
            check($sformatf("v%0d_overflow", v), 32'(overflow), 32'(vecs[v].exp_ovf));
`endif
        end

        // HALT as first word: no load, no write, done two cycles after start
        rom[0] = mk(HLT, 6'd0, 6'd0, 6'd0);
        w0 = wr_count;
        l0 = lh_cycles;
        run_prog(20, cyc);
        check("halt_latency", 32'(cyc), 32'd2);
        check("halt_done_busy", 32'({done, busy}), 32'b10);
        check("halt_no_load", 32'(lh_cycles - l0), 32'd0);
        check("halt_no_write", 32'(wr_count - w0), 32'd0);

        // Full ROM of ADDs, with a start pulse mid-run that must be ignored
        poke(6'd1, 8'd3);
        poke(6'd2, 8'd4);
        for (int i = 0; i < 32; i++) rom[i] = mk(ADD, 6'd1, 6'd2, 6'(10 + i));
        w0 = wr_count;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 400) begin
            start = (cyc == 50);
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check("fill_done", 32'(done), 32'd1);
        check("fill_latency", 32'(cyc), 32'd256);
        check("fill_writes", 32'(wr_count - w0), 32'd32);
        check("fill_pc_held", 32'(imem_addr), 32'd31);
        good = 0;
        for (int i = 0; i < 32; i++) if (dmem[10 + i] == 8'd7) good++;
        check("fill_results", 32'(good), 32'd32);
        repeat (20) @(posedge clk);
        #1;
        check("fill_no_wrap", 32'({done, 8'(wr_count - w0)}), 32'({1'b1, 8'd32}));

        // Reset in the second LOAD cycle aborts the instruction
        poke(6'd1, 8'd5);
        poke(6'd2, 8'd7);
        poke(6'd50, 8'h55);
        rom[0] = mk(ADD, 6'd1, 6'd2, 6'd50);
        rom[1] = mk(HLT, 6'd0, 6'd0, 6'd0);
        w0 = wr_count;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 20 && !lh_enable; k++) begin
            @(posedge clk);
            #1;
        end
        check("abort_reached_load", 32'(lh_enable), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_lh_enable", 32'(lh_enable), 32'd0);
        check("abort_outputs", 32'({mem_we, mem_addr, mem_wdata, imem_addr, busy, done}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_no_write", 32'({dmem[50], 8'(wr_count - w0)}), 32'({8'h55, 8'd0}));
        @(posedge clk);
        #1;
        run_prog(40, cyc);
        check("rerun_latency", 32'(cyc), 32'd10);
        check("rerun_result", 32'(dmem[50]), 32'd12);
        check("rerun_writes", 32'(wr_count - w0), 32'd1);

        // Whole-run protocol checks
        check("we_only_in_store", 32'(viol_we), 32'd0);
        check("mem_addr_idle_zero", 32'(viol_addr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
